// File: rtl/alu_sequencer.sv
// Operand/select sequencer in front of a 4-bit ALU. It captures operands on a button
// press and registers result and flags. It runs one operation, or sweeps all four selects.
module alu_sequencer #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_n,
  input  logic [3:0] a_in,
  input  logic [1:0] b_in,
  input  logic [1:0] sel_in,
  input  logic       mode,
  input  logic [3:0] y_in,
  input  logic [3:0] flags_in,
  output logic [3:0] alu_a,
  output logic [1:0] alu_b,
  output logic [1:0] alu_sel,
  output logic [3:0] y_out,
  output logic [3:0] flags_out,
  output logic [3:0] sticky_flags,
  output logic       busy,
  output logic       done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD, DONE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   press;
  logic [CW-1:0]          cnt;
  logic                   run_auto;
  logic                   hold_end;
  logic                   step_more;

  // Synchronizer idles high (button released), so reset cannot fake a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], start_n};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press     = prev_q & ~sync_q[SYNC_STAGES-1];
  assign hold_end  = (cnt == CNT_LAST);
  assign step_more = run_auto && (alu_sel != 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (press) state_nxt = EXEC;
      EXEC:    state_nxt = HOLD;
      HOLD:    if (hold_end) state_nxt = step_more ? EXEC : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= '0;
      y_out        <= '0;
      flags_out    <= '0;
      sticky_flags <= '0;
      run_auto     <= 1'b0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: if (press) begin
          alu_a        <= a_in;
          alu_b        <= b_in;
          alu_sel      <= mode ? 2'd0 : sel_in;
          run_auto     <= mode;
          sticky_flags <= '0;
        end
        EXEC: begin
          y_out        <= y_in;
          flags_out    <= flags_in;
          sticky_flags <= sticky_flags | flags_in;
          cnt          <= '0;
        end
        HOLD: begin
          if (hold_end) begin
            if (step_more) alu_sel <= alu_sel + 2'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == EXEC) || (state == HOLD);
  assign done = (state == DONE);

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Sequencing controller placed between the board inputs (switches, push-button) and the 4-bit ALU. On a button press it captures operands, drives the ALU operand and select lines from registers, and registers the ALU result and Z/N/C/V flags for the 7-segment display and LEDs. In single mode it runs one operation. In auto mode it steps through all four ALU operations, holding each result for a programmable dwell time, and also keeps sticky flags.

Parameters:
TICK_DIV, 50_000_000, dwell time per result in clk cycles (1 s at 50 MHz); legal range ≥ 1; benches use 4
SYNC_STAGES, 2, synchronizer depth for start_n; fixed at 2 for the timing below

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start_n  input  1  raw push-button, active-low, asynchronous to clk
a_in  input  4  operand A from switches
b_in  input  2  operand B from switches
sel_in  input  2  operation select used in single mode
mode  input  1  0 = single operation, 1 = auto sweep of sel 0..3
y_in  input  4  ALU result Y
flags_in  input  4  ALU flags {V,C,N,Z}
alu_a  output  4  registered operand A to the ALU
alu_b  output  2  registered operand B to the ALU
alu_sel  output  2  registered select to the ALU
y_out  output  4  registered result, feeds the display decoder
flags_out  output  4  registered flags {V,C,N,Z}; bit0 = Z, matching the LED order
sticky_flags  output  4  OR of all flags captured since the last start
busy  output  1  high in EXEC and HOLD
done  output  1  one-cycle pulse at the end of a run

Behaviour:
- Reset, asynchronous: state = IDLE; all outputs = 0; synchronizer flops = 1; hold counter = 0.
- start_n path:
  - 2-flop synchronizer, then a registered previous-value flop.
  - press = prev & ~sync (falling edge). It is asserted in the cycle after the 2nd sampling edge.
  - A press seen in any state other than IDLE is ignored. Holding the button does not retrigger.
- States: IDLE, EXEC, HOLD, DONE.
- IDLE → EXEC on press. On that edge:
  - alu_a ← a_in, alu_b ← b_in
  - alu_sel ← (mode ? 0 : sel_in)
  - mode is latched into a run-mode register for the whole run
  - sticky_flags ← 0
- EXEC: one cycle for the combinational ALU to settle. On exit:
  - y_out ← y_in, flags_out ← flags_in
  - sticky_flags ← sticky_flags | flags_in
  - hold counter ← 0
  - next state = HOLD
- HOLD: counter increments each cycle. When it reaches TICK_DIV−1, the state exits on that edge, so HOLD lasts exactly TICK_DIV cycles.
  - Exit with run-mode = auto and alu_sel < 3: alu_sel ← alu_sel + 1, next state = EXEC.
  - Otherwise: next state = DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. y_out, flags_out and sticky_flags keep their values until the next start.
- Timing, with start_n sampled low at edge 0:
  - Edge 2: enter EXEC, operands registered.
  - Edge 3: y_out/flags_out valid.
  - Each auto step takes TICK_DIV+1 cycles.
  - A single run ends with done high in the cycle after edge 3+TICK_DIV.
- Changes to a_in/b_in/sel_in/mode during a run have no effect on the run.
- alu_sel never wraps. An auto run always stops after sel = 3.
- Reset asserted mid-run aborts immediately to the reset values. There is no done pulse.
- busy and done are never high in the same cycle.

Test Plan:
1. Reset: assert rst_n=0 mid-HOLD → all outputs 0 asynchronously, state IDLE. Release, then press → normal run.
2. Single run, TICK_DIV=4, a_in=4'h9, b_in=2'h3, sel_in=2, mode=0; press at edge 0 → alu_a=9, alu_b=3, alu_sel=2 at edge 2; y_out=y_in and flags_out=flags_in at edge 3; busy for 5 cycles; done for 1 cycle; back to IDLE.
3. Auto run, mode=1, ALU model connected → alu_sel sequence 0,1,2,3 with 5-cycle spacing. Four captures. sticky_flags = OR of the four flag vectors. Exactly one done pulse.
4. Ignored press: press again during HOLD, and toggle a_in/mode mid-run → no restart, alu_a unchanged. A held button produces exactly one run.
5. Sticky clear: a run producing Z=1, followed by a run with all flags 0 → sticky_flags = 0 after the second run's first EXEC.
6. Boundary TICK_DIV=1 → HOLD lasts one cycle; auto run completes in 8 cycles from EXEC entry to the DONE state.
